// File: rtl/router_wh_xbar.sv
// rtl/router_wh_xbar.sv - wormhole crossbar router with per-input flit FIFOs
//
// Purpose: NUM_PORTS x NUM_PORTS wormhole crossbar. Each input buffers flits in
// a FIFO. Each output arbitrates round-robin among inputs whose head flit targets
// it, then stays locked to the winner until the packet's tail has passed.
// Flit type is the top two bits: 00 head, 01 body, 10 tail, 11 head-tail.
//
// Ports:
//   clk, arst      clock, synchronous active-high reset
//   in_valid_i     per-input flit valid
//   in_ready_o     per-input ready (FIFO not full, low during reset)
//   in_flit_i      per-input flit, FLIT_WIDTH bits each
//   in_dest_i      per-input destination index (head/head-tail flits only)
//   out_valid_o    per-output flit valid
//   out_ready_i    per-output ready
//   out_flit_o     per-output flit, zero while out_valid_o is low
//   stat_flits_o   per-output 16-bit saturating flit count
//                  (only with ROUTER_WH_XBAR_STATS_EN defined)
module router_wh_xbar #(
   parameter int NUM_PORTS  = 5,
   parameter int FLIT_WIDTH = 34,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                   clk,
   input  logic                                   arst,
   input  logic [NUM_PORTS-1:0]                   in_valid_i,
   output logic [NUM_PORTS-1:0]                   in_ready_o,
   input  logic [NUM_PORTS*FLIT_WIDTH-1:0]        in_flit_i,
   input  logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] in_dest_i,
   output logic [NUM_PORTS-1:0]                   out_valid_o,
   input  logic [NUM_PORTS-1:0]                   out_ready_i,
   output logic [NUM_PORTS*FLIT_WIDTH-1:0]        out_flit_o
`ifdef ROUTER_WH_XBAR_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0]                stat_flits_o
`endif
);

   localparam int DW = $clog2(NUM_PORTS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [1:0]  T_HEAD   = 2'b00;

   // input FIFOs
   logic [FLIT_WIDTH-1:0] fifo_flit [NUM_PORTS][FIFO_DEPTH];
   logic [DW-1:0]         fifo_dest [NUM_PORTS][FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr    [NUM_PORTS];
   logic [AW-1:0]         rd_ptr    [NUM_PORTS];
   logic [AW:0]           count     [NUM_PORTS];
   logic [NUM_PORTS-1:0]  drop;

   // output state: locked/owner is the LOCKED(owner) state, otherwise IDLE
   logic [NUM_PORTS-1:0]  locked;
   logic [DW-1:0]         owner     [NUM_PORTS];
   logic [DW-1:0]         rr        [NUM_PORTS];
   // an IDLE grant refused by out_ready_i is held so the offered flit stays stable
   logic [NUM_PORTS-1:0]  hold_v;
   logic [DW-1:0]         hold_idx  [NUM_PORTS];

   logic [NUM_PORTS-1:0]  nonempty, push, pop, discard, in_locked, gnt_v, out_xfer;
   logic [FLIT_WIDTH-1:0] hd_flit   [NUM_PORTS];
   logic [DW-1:0]         hd_dest   [NUM_PORTS];
   logic [1:0]            hd_type   [NUM_PORTS];
   logic [DW-1:0]         gnt_idx   [NUM_PORTS];
   logic [DW-1:0]         sel       [NUM_PORTS];

   // FIFO heads, input handshake and discard decisions
   always_comb begin
      in_locked  = '0;
      in_ready_o = '0;
      push       = '0;
      nonempty   = '0;
      discard    = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (locked[o]) in_locked[owner[o]] = 1'b1;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         nonempty[i]   = (count[i] != '0);
         hd_flit[i]    = fifo_flit[i][rd_ptr[i]];
         hd_dest[i]    = fifo_dest[i][rd_ptr[i]];
         hd_type[i]    = hd_flit[i][FLIT_WIDTH-1 -: 2];
         in_ready_o[i] = (count[i] != FULL_CNT) && !arst;
         push[i]       = in_valid_i[i] && in_ready_o[i];
         // drop mode, orphan body/tail, or head naming a nonexistent output
         discard[i]    = nonempty[i] && !in_locked[i] &&
                         (drop[i] || (hd_type[i][1] != hd_type[i][0]) ||
                          (int'(hd_dest[i]) >= NUM_PORTS));
      end
   end

   // arbitration, output muxing and pop generation
   always_comb begin
      int idx;
      idx         = 0;
      pop         = discard;
      gnt_v       = '0;
      out_valid_o = '0;
      out_xfer    = '0;
      out_flit_o  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt_idx[o] = '0;
         if (hold_v[o]) begin
            gnt_v[o]   = 1'b1;
            gnt_idx[o] = hold_idx[o];
         end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               idx = int'(rr[o]) + k;
               if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
               // head types (00, 11) have equal type bits
               if (!gnt_v[o] && nonempty[idx] && !drop[idx] && !in_locked[idx] &&
                   (hd_type[idx][1] == hd_type[idx][0]) && (hd_dest[idx] == DW'(o))) begin
                  gnt_v[o]   = 1'b1;
                  gnt_idx[o] = DW'(idx);
               end
            end
         end
         sel[o]         = locked[o] ? owner[o] : gnt_idx[o];
         out_valid_o[o] = !arst && (locked[o] ? nonempty[owner[o]] : gnt_v[o]);
         out_flit_o[o*FLIT_WIDTH +: FLIT_WIDTH] = out_valid_o[o] ? hd_flit[sel[o]] : '0;
         out_xfer[o]    = out_valid_o[o] && out_ready_i[o];
         if (out_xfer[o]) pop[sel[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         drop   <= '0;
         locked <= '0;
         hold_v <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            count[i]    <= '0;
            owner[i]    <= '0;
            rr[i]       <= '0;
            hold_idx[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
               fifo_flit[i][wr_ptr[i]] <= in_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
               fifo_dest[i][wr_ptr[i]] <= in_dest_i[i*DW +: DW];
               wr_ptr[i]               <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
            else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
            if (discard[i]) begin
               // tail or head-tail ends drop mode; a bad-dest head starts it
               if (drop[i]) begin
                  if (hd_type[i][1]) drop[i] <= 1'b0;
               end else if (hd_type[i] == T_HEAD) begin
                  drop[i] <= 1'b1;
               end
            end
         end
         for (int o = 0; o < NUM_PORTS; o++) begin
            hold_v[o]   <= gnt_v[o] && !locked[o] && !out_ready_i[o];
            hold_idx[o] <= gnt_idx[o];
            if (out_xfer[o]) begin
               if (locked[o]) begin
                  if (hd_type[sel[o]][1]) locked[o] <= 1'b0;
               end else begin
                  rr[o] <= (int'(gnt_idx[o]) == NUM_PORTS-1) ? '0 : gnt_idx[o] + 1'b1;
                  if (hd_type[sel[o]] == T_HEAD) begin
                     locked[o] <= 1'b1;
                     owner[o]  <= sel[o];
                  end
               end
            end
         end
      end
   end

`ifdef ROUTER_WH_XBAR_STATS_EN
   logic [15:0] stat_cnt [NUM_PORTS];

   always_ff @(posedge clk) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (arst) stat_cnt[o] <= '0;
         else if (out_xfer[o] && stat_cnt[o] != 16'hFFFF) stat_cnt[o] <= stat_cnt[o] + 1'b1;
      end
   end

   always_comb begin
      stat_flits_o = '0;
      for (int o = 0; o < NUM_PORTS; o++) stat_flits_o[o*16 +: 16] = stat_cnt[o];
   end
`endif

endmodule

// File: tb/tb_router_wh_xbar.sv
// tb/tb_router_wh_xbar.sv - self-checking bench for router_wh_xbar
module tb_router_wh_xbar;
   localparam int NP = 5, FW = 34, DW = 3, DEPTH = 4;
   typedef logic [FW-1:0]    flit_t;
   typedef logic [DW+FW-1:0] ent_t;

   logic clk = 1'b0;
   logic arst;
   logic [NP-1:0]    in_valid, in_ready, out_valid, out_ready;
   logic [NP*FW-1:0] in_flit, out_flit;
   logic [NP*DW-1:0] in_dest;
`ifdef ROUTER_WH_XBAR_STATS_EN
   logic [NP*16-1:0] stat_flits;
`endif

   router_wh_xbar #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .arst(arst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_flit_i(in_flit), .in_dest_i(in_dest),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_flit_o(out_flit)
`ifdef ROUTER_WH_XBAR_STATS_EN
      , .stat_flits_o(stat_flits)
`endif
   );

   always #5 clk = ~clk;

   ent_t  in_q    [NP][$];     // pending stimulus per input {dest, flit}
   flit_t exp_q   [NP*NP][$];  // expected flits per (input, output) pair, in order
   flit_t out_log [NP][$];     // flits observed per output
   logic [NP-1:0] hold_v;
   flit_t hold_f [NP];
   logic [NP-1:0] rdy_mask;
   bit rand_v, rand_r;
   int n_chk, n_pass, seq;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // flit payload carries source input, packet number and index for scoreboarding
   task automatic send_pkt(input int src, input int dest, input int len);
      flit_t f;
      logic [1:0] t;
      seq++;
      for (int k = 0; k < len; k++) begin
         t = (len == 1) ? 2'b11 : (k == 0) ? 2'b00 : (k == len-1) ? 2'b10 : 2'b01;
         f = {t, 4'(src), 4'h0, 16'(seq), 8'(k)};
         in_q[src].push_back({3'(dest), f});
         if (dest < NP) exp_q[src*NP+dest].push_back(f);
      end
   endtask

   task automatic send_orphan(input int src);
      flit_t f;
      seq++;
      f = {($urandom_range(0,1) != 0) ? 2'b01 : 2'b10, 4'(src), 4'h0, 16'(seq), 8'h0};
      in_q[src].push_back({3'($urandom_range(0,7)), f});
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NP; i++) n += in_q[i].size();
      return n;
   endfunction

   // one clock: drive at posedge+1, sample at negedge, return at next posedge+1
   task automatic cycle();
      ent_t e;
      flit_t f;
      for (int i = 0; i < NP; i++) begin
         if (in_q[i].size() > 0 && (!rand_v || $urandom_range(0,3) != 0)) begin
            e = in_q[i][0];
            in_valid[i] = 1'b1;
            in_flit[i*FW +: FW] = e[FW-1:0];
            in_dest[i*DW +: DW] = e[FW+DW-1:FW];
         end else begin
            in_valid[i] = 1'b0;
            in_flit[i*FW +: FW] = '0;
            in_dest[i*DW +: DW] = '0;
         end
      end
      for (int o = 0; o < NP; o++) out_ready[o] = rdy_mask[o] && (!rand_r || $urandom_range(0,3) != 0);
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (in_valid[i] && in_ready[i]) e = in_q[i].pop_front();
      for (int o = 0; o < NP; o++) begin
         f = out_flit[o*FW +: FW];
         if (hold_v[o]) begin
            check("hold_valid", out_valid[o], 1);
            check("hold_flit", f, hold_f[o]);
         end
         if (!out_valid[o]) check("idle_zero", f, 0);
         else if (out_ready[o]) out_log[o].push_back(f);
         hold_v[o] = out_valid[o] && !out_ready[o];
         hold_f[o] = f;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int budget);
      int c = 0;
      while (pending() > 0 && c < budget) begin
         cycle();
         c++;
      end
      check("drain", pending(), 0);
      for (int k = 0; k < 60; k++) cycle();
   endtask

   // per-output: packets never interleave, per-source order matches, nothing extra/missing
   task automatic verify();
      flit_t f;
      int s, cur;
      for (int o = 0; o < NP; o++) begin
         cur = -1;
         for (int k = 0; k < out_log[o].size(); k++) begin
            f = out_log[o][k];
            s = int'(f[31:28]);
            if (cur >= 0) check("no_interleave", s, cur);
            if (s < NP && exp_q[s*NP+o].size() > 0) check("sb_flit", f, exp_q[s*NP+o].pop_front());
            else check("sb_extra", f, 0);
            if (f[33:32] == 2'b00) cur = s;
            else if (f[33]) cur = -1;
         end
         out_log[o].delete();
      end
      for (int q = 0; q < NP*NP; q++) check("sb_missing", exp_q[q].size(), 0);
   endtask

   task automatic do_reset();
      arst = 1'b1;
      in_valid = '0; in_flit = '0; in_dest = '0; out_ready = '1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_flit", |out_flit, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_in_ready_after_edge", in_ready, 0);
      check("rst_out_valid_after_edge", out_valid, 0);
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", in_ready, 5'h1f);
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
         in_q[i].delete();
         out_log[i].delete();
      end
      for (int q = 0; q < NP*NP; q++) exp_q[q].delete();
      hold_v = '0;
   endtask

   initial begin
      flit_t ht;
      int r;
      n_chk = 0; n_pass = 0; seq = 0;
      rand_v = 0; rand_r = 0; rdy_mask = '1; hold_v = '0;
      arst = 1'b1; in_valid = '0; in_flit = '0; in_dest = '0; out_ready = '0;
      do_reset();

      // single head-tail, input 4 -> output 0, one-cycle latency
      ht = 34'h3_0000_00AA;
      in_valid = 5'b10000; in_flit[4*FW +: FW] = ht; in_dest[4*DW +: DW] = 3'd0; out_ready = '1;
      @(negedge clk);
      check("ht_accept", in_ready[4], 1);
      check("ht_not_same_cycle", out_valid, 0);
      @(posedge clk); #1;
      in_valid = '0; in_flit = '0;
      @(negedge clk);
      check("ht_valid", out_valid, 5'b00001);
      check("ht_flit", out_flit[0 +: FW], ht);
      @(posedge clk); #1;
      @(negedge clk);
      check("ht_gone", out_valid, 0);
      @(posedge clk); #1;
      send_pkt(1, 0, 2);              // output 0 must still be IDLE
      run(100);
      verify();

      // three simultaneous packets to output 0: order 1,2,3 then round moves to 4
      do_reset();
      send_pkt(1, 0, 3); send_pkt(2, 0, 3); send_pkt(3, 0, 3);
      run(200);
      check("rr_count", out_log[0].size(), 9);
      for (int k = 0; k < 3; k++)
         check("rr_order", (out_log[0].size() > k*3) ? out_log[0][k*3][31:28] : 4'hF, k+1);
      verify();
      send_pkt(0, 0, 2); send_pkt(4, 0, 2);
      run(200);
      check("rr_next_first", (out_log[0].size() > 0) ? out_log[0][0][31:28] : 4'hF, 4);
      check("rr_next_second", (out_log[0].size() > 2) ? out_log[0][2][31:28] : 4'hF, 0);
      verify();

      // backpressure on output 2: exactly DEPTH flits accepted, then in order
      do_reset();
      send_pkt(0, 2, 4); send_pkt(0, 2, 1);
      rdy_mask = 5'b11011;
      for (int k = 0; k < 10; k++) cycle();
      check("bp_in_ready", in_ready[0], 0);
      check("bp_accepted", in_q[0].size(), 1);
      check("bp_stall_valid", out_valid[2], 1);
      check("bp_none_out", out_log[2].size(), 0);
      rdy_mask = '1;
      run(200);
      verify();

      // bad destination packet dropped, following packet delivered
      send_pkt(3, 7, 3); send_pkt(3, 1, 2);
      run(200);
      verify();

      // reset after 2 of 4 flits out, then a fresh packet with no residue
      send_pkt(0, 2, 4);
      rdy_mask = 5'b11011;
      for (int k = 0; k < 6; k++) cycle();
      rdy_mask = '1;
      for (int c = 0; c < 50 && out_log[2].size() < 2; c++) cycle();
      check("mid_two_out", out_log[2].size(), 2);
      do_reset();
      send_pkt(1, 2, 2);
      run(200);
      verify();

      // randomized traffic with contention, drops, orphans and random backpressure
      do_reset();
      rand_v = 1; rand_r = 1;
      for (int i = 0; i < NP; i++) begin
         for (int p = 0; p < 15; p++) begin
            r = $urandom_range(0, 9);
            if (r < 7) send_pkt(i, $urandom_range(0, NP-1), $urandom_range(1, 4));
            else if (r < 8) send_pkt(i, $urandom_range(NP, 7), $urandom_range(1, 4));
            else send_orphan(i);
         end
      end
      run(4000);
      verify();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
